// File: rtl/ifmap_pkg.sv
// Shared definitions for the ifmap fetch controller.
//   - FSM state type and encodings
//   - FIFO_DEPTH: depth of the staging FIFO between global buffer and PE stream
//   - default bitwidths for data, address and row-count/length fields
package ifmap_pkg;

  localparam int FIFO_DEPTH        = 4;
  localparam int DEF_DATA_BITWIDTH = 16;
  localparam int DEF_ADDR_BITWIDTH = 10;
  localparam int DEF_CNT_BITWIDTH  = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/ifmap_fetch_fifo.sv
// Small synchronous FIFO staging global-buffer read data for the PE stream.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   flush           synchronous clear; wins over push/pop in the same cycle
//   push, push_data write side; a push while full is accepted only with a pop
//   pop, pop_data   read side; pop_data is the head entry (first-word fall-through)
//   count, empty    occupancy and empty flag
// DEPTH must be a power of two so the pointers wrap naturally.
module ifmap_fetch_fifo import ifmap_pkg::*; #(
  parameter int WIDTH = DEF_DATA_BITWIDTH + 2,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             full, do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a full FIFO can still take a word when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = wr_q + PW'(1);
      end
      if (do_pop) rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign pop_data = mem_q[rd_q];
  assign count    = cnt_q;

endmodule

// File: rtl/ifmap_fetch_ctrl.sv
// Ifmap tile fetch controller: walks a num_rows x row_len tile in the global
// buffer (row starts spaced by row_stride), stages the returned words in a
// small FIFO and streams them to the PE array with row/tile-last sideband.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, abort               begin a tile (IDLE only) / cancel the current tile
//   base_addr, num_rows,
//   row_len, row_stride        tile configuration, latched on start
//   gb_read_req, gb_r_addr     read request to the global buffer (registered)
//   gb_r_data                  read data, one cycle after the request is sampled
//   out_valid/out_ready/out_data, out_row_last, out_tile_last   output stream
//   busy, done                 status; done pulses once per completed tile
module ifmap_fetch_ctrl import ifmap_pkg::*; #(
  parameter int DATA_BITWIDTH = DEF_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH = DEF_ADDR_BITWIDTH,
  parameter int CNT_BITWIDTH  = DEF_CNT_BITWIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_BITWIDTH-1:0] base_addr,
  input  logic [CNT_BITWIDTH-1:0]  num_rows,
  input  logic [CNT_BITWIDTH-1:0]  row_len,
  input  logic [ADDR_BITWIDTH-1:0] row_stride,
  output logic                     gb_read_req,
  output logic [ADDR_BITWIDTH-1:0] gb_r_addr,
  input  logic [DATA_BITWIDTH-1:0] gb_r_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic                     out_row_last,
  output logic                     out_tile_last,
  output logic                     busy,
  output logic                     done
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  state_t                   state_q, state_d;
  logic [CNT_BITWIDTH-1:0]  rows_q, rows_d, len_q, len_d, row_q, row_d, col_q, col_d;
  logic [ADDR_BITWIDTH-1:0] stride_q, stride_d, row_base_q, row_base_d, addr_q, addr_d;
  // req_*: read on the bus this cycle; rdv_*: its data is on gb_r_data this cycle
  logic                     req_q, req_d, req_rl_q, req_rl_d, req_tl_q, req_tl_d;
  logic                     rdv_q, rdv_d, rdv_rl_q, rdv_rl_d, rdv_tl_q, rdv_tl_d;

  logic [FCW-1:0]             fifo_count, pending;
  logic                       fifo_empty, pop, flush, can_issue, last_col, last_row, drain_done;
  logic [DATA_BITWIDTH+1:0]   head;

  assign flush    = abort && (state_q != ST_IDLE);
  assign pop      = out_valid && out_ready;
  // words that will land in the FIFO if nothing drains: stored + both pipeline slots
  assign pending  = fifo_count + {{(FCW-1){1'b0}}, req_q} + {{(FCW-1){1'b0}}, rdv_q};
  assign can_issue = (state_q == ST_FETCH) && !abort && (pending < FCW'(FIFO_DEPTH));
  assign last_col = (col_q == len_q - CNT_BITWIDTH'(1));
  assign last_row = (row_q == rows_q - CNT_BITWIDTH'(1));
  // look at the FIFO after this cycle's pop so done follows the last word directly
  assign drain_done = !req_q && !rdv_q &&
                      ((fifo_count == '0) || ((fifo_count == FCW'(1)) && pop));

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    len_d      = len_q;
    stride_d   = stride_q;
    row_base_d = row_base_q;
    row_d      = row_q;
    col_d      = col_q;
    addr_d     = addr_q;
    req_d      = 1'b0;
    req_rl_d   = 1'b0;
    req_tl_d   = 1'b0;
    rdv_d      = req_q;
    rdv_rl_d   = req_rl_q;
    rdv_tl_d   = req_tl_q;
    case (state_q)
      ST_IDLE: if (start) begin
        rows_d     = num_rows;
        len_d      = row_len;
        stride_d   = row_stride;
        row_base_d = base_addr;
        row_d      = '0;
        col_d      = '0;
        state_d    = (num_rows == '0 || row_len == '0) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: if (can_issue) begin
        req_d    = 1'b1;
        addr_d   = row_base_q + ADDR_BITWIDTH'(col_q);
        req_rl_d = last_col;
        req_tl_d = last_col && last_row;
        if (last_col) begin
          col_d      = '0;
          row_d      = row_q + CNT_BITWIDTH'(1);
          row_base_d = row_base_q + stride_q;
          if (last_row) state_d = ST_DRAIN;
        end else begin
          col_d = col_q + CNT_BITWIDTH'(1);
        end
      end
      ST_DRAIN: if (drain_done) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
    // cancel drops the request in flight; its returning data is never pushed
    if (flush) begin
      state_d = ST_IDLE;
      req_d   = 1'b0;
      rdv_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rows_q     <= '0;
      len_q      <= '0;
      stride_q   <= '0;
      row_base_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      req_q      <= 1'b0;
      req_rl_q   <= 1'b0;
      req_tl_q   <= 1'b0;
      rdv_q      <= 1'b0;
      rdv_rl_q   <= 1'b0;
      rdv_tl_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      len_q      <= len_d;
      stride_q   <= stride_d;
      row_base_q <= row_base_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      req_rl_q   <= req_rl_d;
      req_tl_q   <= req_tl_d;
      rdv_q      <= rdv_d;
      rdv_rl_q   <= rdv_rl_d;
      rdv_tl_q   <= rdv_tl_d;
    end
  end

  ifmap_fetch_fifo #(
    .WIDTH (DATA_BITWIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (rdv_q),
    .push_data ({rdv_tl_q, rdv_rl_q, gb_r_data}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign gb_read_req   = req_q;
  assign gb_r_addr     = addr_q;
  assign out_valid     = !fifo_empty;
  assign out_data      = out_valid ? head[DATA_BITWIDTH-1:0] : '0;
  assign out_row_last  = out_valid && head[DATA_BITWIDTH];
  assign out_tile_last = out_valid && head[DATA_BITWIDTH+1];
  // busy covers the accepting cycle itself, hence the combinational start term
  assign busy          = (state_q != ST_IDLE) || (start && !reset);
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_ifmap_fetch_ctrl.sv
module tb_ifmap_fetch_ctrl;
  localparam int DW = 16, AW = 10, CW = 8;

  logic          clk = 1'b0;
  logic          reset, start, abort, out_ready;
  logic [AW-1:0] base_addr, row_stride, gb_r_addr;
  logic [CW-1:0] num_rows, row_len;
  logic          gb_read_req, out_valid, out_row_last, out_tile_last, busy, done;
  logic [DW-1:0] gb_r_data, out_data;

  always #5 clk = ~clk;

  ifmap_fetch_ctrl #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .CNT_BITWIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .num_rows(num_rows), .row_len(row_len), .row_stride(row_stride),
    .gb_read_req(gb_read_req), .gb_r_addr(gb_r_addr), .gb_r_data(gb_r_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row_last(out_row_last), .out_tile_last(out_tile_last), .busy(busy), .done(done)
  );

  // global buffer: data valid the cycle after the request is sampled
  logic [DW-1:0] gbmem [1024];
  always @(posedge clk) if (gb_read_req) gb_r_data <= gbmem[gb_r_addr];

  typedef struct packed { logic [DW-1:0] data; logic rl; logic tl; } word_t;

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: tile as address / word lists ----------------
  logic [AW-1:0] addr_q [$];
  word_t         exp_q  [$];

  function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] b, input logic [AW-1:0] s,
                                           input int len, input int k);
    return AW'(b + AW'(k / len) * s + AW'(k % len));
  endfunction

  task automatic build(input logic [AW-1:0] b, input int rows, input int len, input logic [AW-1:0] s);
    word_t w;
    addr_q.delete();
    exp_q.delete();
    for (int k = 0; k < rows * len; k++) begin
      addr_q.push_back(addr_of(b, s, len, k));
      w.data = gbmem[addr_of(b, s, len, k)];
      w.rl   = (k % len == len - 1);
      w.tl   = (k == rows * len - 1);
      exp_q.push_back(w);
    end
  endtask

  // ---------------- compare process ----------------
  logic          active = 1'b0, exp_done_next = 1'b0, stall = 1'b0;
  word_t         stall_word;
  int            cyc = 0, reads_seen = 0, acc = 0, busy_cnt = 0, done_cnt = 0;
  int            start_cyc = 0, first_valid_cyc = -1, last_acc_cyc = 0, done_cyc = 0;
  logic [AW-1:0] obs_addr [$];

  always @(negedge clk) begin : mon
    logic  was_active;
    word_t w, cur;
    cyc++;
    cur = {out_data, out_row_last, out_tile_last};
    if (reset) begin
      active = 1'b0; exp_done_next = 1'b0; stall = 1'b0;
      addr_q.delete(); exp_q.delete();
    end else begin
      was_active = active;
      chk("busy", busy, active || start);
      chk("done", done, exp_done_next);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (exp_done_next) active = 1'b0;
      exp_done_next = 1'b0;
      if (abort && active) begin
        active = 1'b0; stall = 1'b0;
        addr_q.delete(); exp_q.delete();
      end else begin
        if (gb_read_req) begin
          reads_seen++;
          obs_addr.push_back(gb_r_addr);
          if (addr_q.size() == 0) chk("unexpected_read", gb_read_req, 1'b0);
          else begin
            chk("rd_addr", gb_r_addr, addr_q.pop_front());
            chk("occupancy", (reads_seen - acc) <= 4, 1'b1);
          end
        end
        if (stall) begin
          chk("hold_valid", out_valid, 1'b1);
          chk("hold_word", cur, stall_word);
        end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid && exp_q.size() == 0) chk("unexpected_valid", out_valid, 1'b0);
        else if (out_valid && out_ready) begin
          w = exp_q.pop_front();
          chk("out_word", cur, w);
          acc++;
          last_acc_cyc = cyc;
          if (w.tl) exp_done_next = 1'b1;
        end
        stall      = out_valid && !out_ready;
        stall_word = cur;
      end
      if (start && !was_active) begin
        active = 1'b1;
        build(base_addr, int'(num_rows), int'(row_len), row_stride);
        reads_seen = 0; acc = 0; busy_cnt = 0; done_cnt = 0;
        start_cyc = cyc + 1; first_valid_cyc = -1;
        obs_addr.delete();
        if (num_rows == '0 || row_len == '0) exp_done_next = 1'b1;
      end
      if (busy) busy_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  int rdy_mode = 0; // 0: ready high, 1: random, 2: ready low
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic start_tile(input logic [AW-1:0] b, input logic [CW-1:0] r,
                            input logic [CW-1:0] l, input logic [AW-1:0] s);
    @(posedge clk); #1;
    base_addr = b; num_rows = r; row_len = l; row_stride = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // scribble over the config: the latched tile must not change
    base_addr = AW'($urandom); num_rows = CW'($urandom);
    row_len = CW'($urandom); row_stride = AW'($urandom);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < max);
    #1;
    chk("wait_idle", busy, 1'b0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_req"}, gb_read_req, 1'b0);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_rl"}, out_row_last, 1'b0);
    chk({tag, "_tl"}, out_tile_last, 1'b0);
    chk({tag, "_addr"}, gb_r_addr, '0);
    chk({tag, "_data"}, out_data, '0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : drv
    logic [AW-1:0] e1 [6];
    logic [AW-1:0] e3 [4];
    int n;
    int r, l, act;
    e1[0] = 10'h010; e1[1] = 10'h011; e1[2] = 10'h012;
    e1[3] = 10'h030; e1[4] = 10'h031; e1[5] = 10'h032;
    e3[0] = 10'h3FE; e3[1] = 10'h3FF; e3[2] = 10'h000; e3[3] = 10'h001;
    for (int i = 0; i < 1024; i++) gbmem[i] = DW'($urandom);
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    base_addr = '0; num_rows = '0; row_len = '0; row_stride = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    reset = 1'b0;

    // basic tile, ready high
    rdy_mode = 0;
    start_tile(10'h010, 8'd2, 8'd3, 10'h020);
    wait_idle(100);
    chk("t1_nreads", obs_addr.size(), 6);
    for (int i = 0; i < 6 && i < obs_addr.size(); i++) chk("t1_addr", obs_addr[i], e1[i]);
    chk("t1_words", acc, 6);
    chk("t1_first_valid_lat", first_valid_cyc - start_cyc, 3);
    chk("t1_done_lat", done_cyc - last_acc_cyc, 1);
    chk("t1_done_cnt", done_cnt, 1);

    // downstream stalled for 10 cycles after start
    rdy_mode = 2;
    start_tile(10'h010, 8'd2, 8'd3, 10'h020);
    repeat (9) @(posedge clk);
    chk("t2_stall_reads", reads_seen, 4);
    rdy_mode = 0;
    wait_idle(100);
    chk("t2_words", acc, 6);

    // address wrap
    start_tile(10'h3FE, 8'd1, 8'd4, 10'h055);
    wait_idle(100);
    chk("t3_nreads", obs_addr.size(), 4);
    for (int i = 0; i < 4 && i < obs_addr.size(); i++) chk("t3_addr", obs_addr[i], e3[i]);

    // empty tiles
    start_tile(10'h100, 8'd0, 8'd5, 10'h010);
    wait_idle(20);
    chk("t4a_reads", reads_seen, 0);
    chk("t4a_busy_cycles", busy_cnt, 2);
    chk("t4a_done_cnt", done_cnt, 1);
    start_tile(10'h100, 8'd3, 8'd0, 10'h010);
    wait_idle(20);
    chk("t4b_reads", reads_seen, 0);
    chk("t4b_busy_cycles", busy_cnt, 2);
    chk("t4b_done_cnt", done_cnt, 1);

    // abort two cycles after the second word
    start_tile(10'h010, 8'd2, 8'd3, 10'h020);
    n = 0;
    while (acc < 2 && n < 50) begin @(posedge clk); n++; end
    chk("t5_reach_word2", acc >= 2, 1'b1);
    #1;
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    #3;
    chk("t5_valid_after_abort", out_valid, 1'b0);
    chk("t5_busy_after_abort", busy, 1'b0);
    repeat (6) @(posedge clk);
    chk("t5_no_done", done_cnt, 0);
    rdy_mode = 1;
    start_tile(10'h100, 8'd2, 8'd2, 10'h010);
    wait_idle(200);
    chk("t5_fresh_words", acc, 4);

    // reset while draining
    rdy_mode = 2;
    start_tile(10'h200, 8'd1, 8'd4, 10'h008);
    repeat (8) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_outs("mid_reset");
    @(posedge clk); #1 reset = 1'b0;
    rdy_mode = 0;
    start_tile(10'h200, 8'd1, 8'd4, 10'h008);
    wait_idle(100);
    chk("t6_words", acc, 4);

    // randomized tiles with random backpressure, aborts and resets
    for (int it = 0; it < 40; it++) begin
      rdy_mode = int'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 4));
      l   = int'($urandom_range(0, 5));
      act = int'($urandom_range(0, 9));
      start_tile(AW'($urandom), CW'(r), CW'(l), AW'($urandom));
      if (act == 0) begin
        repeat ($urandom_range(0, 12)) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
      end else if (act == 1) begin
        repeat ($urandom_range(0, 12)) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
      end
      wait_idle(400);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifmap_fetch_ctrl.md
IFMAP_FETCH_CTRL -- requirements
Module: ifmap_fetch_ctrl

Interface
REQ-001 Parameter DATA_BITWIDTH, default 16, shall set the ifmap word width.
REQ-002 Parameter ADDR_BITWIDTH, default 10, shall set the global-buffer address width.
REQ-003 Parameter CNT_BITWIDTH, default 8, shall set the width of the row-count and row-length fields.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a tile fetch; ignored while busy.
REQ-007 abort  input  1  synchronous cancel of the current fetch.
REQ-008 base_addr  input  ADDR_BITWIDTH  address of the tile's first word.
REQ-009 num_rows  input  CNT_BITWIDTH  rows in the tile.
REQ-010 row_len  input  CNT_BITWIDTH  words per row.
REQ-011 row_stride  input  ADDR_BITWIDTH  address step between row starts.
REQ-012 gb_read_req  output  1  read strobe to the ifmap global buffer.
REQ-013 gb_r_addr  output  ADDR_BITWIDTH  read address to the global buffer.
REQ-014 gb_r_data  input  DATA_BITWIDTH  buffer read data, valid one cycle after gb_read_req is sampled.
REQ-015 out_valid, out_ready, out_data[DATA_BITWIDTH]  output, input, output  valid/ready stream toward the PE array.
REQ-016 out_row_last, out_tile_last  output  1 each  sideband qualifiers of out_data.
REQ-017 busy  output  1  high from start acceptance until done or abort.
REQ-018 done  output  1  one-cycle pulse after the last word is accepted downstream.

Function
REQ-019 The FSM shall have the states IDLE, FETCH, DRAIN and DONE.
REQ-020 Transitions: IDLE->FETCH on start; FETCH->DRAIN after the last read is issued; DRAIN->DONE when the FIFO is empty and no read is in flight; DONE->IDLE unconditionally, with done high for that cycle.
REQ-021 On start, the block shall latch all configuration inputs; later changes to those inputs shall have no effect on the current tile.
REQ-022 Read addresses shall be row_base+col, with row_base starting at base_addr and incrementing by row_stride at each row end; all address arithmetic is modulo 2^ADDR_BITWIDTH.
REQ-023 Reads shall be issued in row-major order: col runs 0..row_len-1, row runs 0..num_rows-1.
REQ-024 gb_read_req shall be asserted only in FETCH and only when FIFO occupancy plus in-flight reads is less than FIFO_DEPTH (4).
REQ-025 gb_r_data shall be written into the FIFO on the cycle after each issued read.
REQ-026 out_valid shall be high exactly when the FIFO is non-empty, and a word shall transfer when out_valid and out_ready are both high.
REQ-027 out_data, out_row_last and out_tile_last shall hold stable while out_valid is high and out_ready is low.
REQ-028 out_row_last shall mark col==row_len-1; out_tile_last shall mark the final word of the tile.
REQ-029 With out_ready held high, the first out_valid shall appear 3 cycles after the start edge, followed by one word per cycle.
REQ-030 If num_rows==0 or row_len==0, the FSM shall go IDLE->DONE without issuing any read.
REQ-031 abort in any non-IDLE state shall, on the next edge, flush the FIFO, discard in-flight data and return the FSM to IDLE without a done pulse.
REQ-032 abort shall take priority over a simultaneous FIFO push or pop.
REQ-033 A simultaneous FIFO push and pop when the FIFO is full shall be legal and shall leave the occupancy unchanged.
REQ-034 When gb_read_req is low, gb_r_addr shall hold its last value.

Reset
REQ-035 Reset shall drive the FSM to IDLE, empty the FIFO and clear all counters and the in-flight flag.
REQ-036 Under reset, busy, done, gb_read_req, out_valid, out_row_last and out_tile_last shall be 0, and gb_r_addr and out_data shall be 0.
REQ-037 Reset asserted mid-tile shall abandon the tile, and the first start after reset deasserts shall be accepted.

Structure
REQ-038 Shared package ifmap_pkg shall hold the FSM state type, FIFO_DEPTH=4 and the default bitwidth constants.
REQ-039 The FIFO shall be a separate sub-module, ifmap_fetch_fifo (depth FIFO_DEPTH, width DATA_BITWIDTH+2, asynchronous reset, with flush input).

Verification
REQ-040 base=0x010, rows=2, len=3, stride=0x020, out_ready=1 -> addresses 010,011,012,030,031,032; six words in order; row_last on words 3 and 6; tile_last on word 6; done 1 cycle after word 6.
REQ-041 Same tile with out_ready low for 10 cycles after start -> at most 4 reads issued, no data loss, output order preserved after release.
REQ-042 base=0x3FE, rows=1, len=4 -> addresses 3FE,3FF,000,001.
REQ-043 rows=0 or len=0 -> no gb_read_req, busy for 2 cycles, single done pulse.
REQ-044 abort 2 cycles after word 2 is output -> out_valid low next cycle, no done, and a subsequent start fetches a fresh tile correctly.
REQ-045 reset pulsed mid-DRAIN -> all outputs 0 immediately, FSM in IDLE, next tile correct.
